// File: rtl/mul_pkg.sv
// mul_pkg: shared product/word geometry and serializer state encoding
package mul_pkg;
  localparam int PROD_W = 1142;
  localparam int WORD_W = 64;
  localparam int WORDS = (PROD_W + WORD_W - 1) / WORD_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
endpackage

// File: rtl/mul_result_serializer.sv
// mul_result_serializer: splits a wide product into WORD_W-bit words over a valid/ready stream
module mul_result_serializer #(
  parameter int PROD_W = mul_pkg::PROD_W,
  parameter int WORD_W = mul_pkg::WORD_W,
  parameter int MSW_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [4:0]        out_idx,
  output logic              overrun
);
  localparam int WORDS = (PROD_W + WORD_W - 1) / WORD_W;
  localparam int TW = WORDS * WORD_W;
  localparam logic [4:0] LAST = 5'(WORDS - 1);
  logic [0:0] state;
  logic [TW-1:0] sh;
  logic [4:0] idx;
  logic hs;
  assign prod_ready = state == mul_pkg::IDLE;
  assign out_valid = state == mul_pkg::SEND;
  assign hs = out_valid && out_ready;
  assign out_idx = idx;
  assign out_last = out_valid && idx == LAST;
  assign out_data = !out_valid ? '0 : MSW_FIRST != 0 ? sh[TW-1 -: WORD_W] : sh[WORD_W-1:0];
  // capture a product, then shift one word toward the output end per handshake
  always_ff @(posedge clk)
    if (rst) begin
      state <= mul_pkg::IDLE;
      sh <= '0;
      idx <= '0;
      overrun <= 1'b0;
    end else begin
      if (prod_valid && !prod_ready) overrun <= 1'b1;
      if (prod_valid && prod_ready) begin
        sh <= TW'(prod);
        state <= mul_pkg::SEND;
      end else if (hs) begin
        sh <= MSW_FIRST != 0 ? sh << WORD_W : sh >> WORD_W;
        idx <= out_last ? '0 : idx + 5'd1;
        if (out_last) state <= mul_pkg::IDLE;
      end
    end
endmodule

// File: tb/tb_mul_result_serializer.sv
// tb_mul_result_serializer: table-driven and random checks of both word orders
module tb_mul_result_serializer;
  localparam int PW = 1142;
  localparam int WW = 64;
  localparam int NW = 18;
  typedef struct {
    logic [PW-1:0] p;
    int            mode;
    logic [WW-1:0] first0;
    logic [WW-1:0] first1;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, prod_valid = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] prod = '0;
  logic prod_ready0, out_valid0, out_last0, overrun0;
  logic prod_ready1, out_valid1, out_last1, overrun1;
  logic [WW-1:0] out_data0, out_data1;
  logic [4:0] out_idx0, out_idx1;
  int errors = 0, checks = 0;
  vec_t tbl[6];
  always #5 clk = ~clk;
  mul_result_serializer #(.PROD_W(PW), .WORD_W(WW), .MSW_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
    .out_idx(out_idx0), .overrun(overrun0));
  mul_result_serializer #(.PROD_W(PW), .WORD_W(WW), .MSW_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
    .out_idx(out_idx1), .overrun(overrun1));
  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [WW-1:0] word_of(input logic [PW-1:0] p, input int k);
    logic [NW*WW-1:0] w;
    w = '0;
    w[PW-1:0] = p;
    return w[k*WW +: WW];
  endfunction
  function automatic logic [PW-1:0] rnd_prod();
    logic [PW-1:0] p;
    for (int i = 0; i < PW; i += 32) p = (p << 32) | PW'($urandom);
    return p;
  endfunction
  task automatic check_idle(input string name);
    check({name, " valid0"}, out_valid0, 0);
    check({name, " valid1"}, out_valid1, 0);
    check({name, " ready0"}, prod_ready0, 1);
    check({name, " ready1"}, prod_ready1, 1);
    check({name, " data0"}, out_data0, 0);
    check({name, " data1"}, out_data1, 0);
    check({name, " idx0"}, out_idx0, 0);
    check({name, " last0"}, out_last0, 0);
  endtask
  task automatic run(input logic [PW-1:0] p, input int mode, input logic [WW-1:0] f0,
                     input logic [WW-1:0] f1, input int ovr_at, input int rst_at, output int cycles);
    int k, phase;
    logic r, pulsed;
    k = 0; phase = 0; cycles = 0; pulsed = 0;
    @(negedge clk);
    check("ready before capture", prod_ready0, 1);
    prod = p;
    prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    while (k < NW && cycles < 200) begin
      cycles++;
      check("valid0", out_valid0, 1);
      check("valid1", out_valid1, 1);
      check("ready0 busy", prod_ready0, 0);
      check("lsw data", out_data0, word_of(p, k));
      check("msw data", out_data1, word_of(p, NW - 1 - k));
      check("idx0", out_idx0, WW'(k));
      check("idx1", out_idx1, WW'(k));
      check("last0", out_last0, WW'(k == NW - 1));
      check("last1", out_last1, WW'(k == NW - 1));
      if (k == 0) begin
        check("table first lsw", out_data0, f0);
        check("table first msw", out_data1, f1);
      end
      if (k == rst_at) begin
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_idle("mid reset");
        check("mid reset overrun", overrun0, 0);
        rst = 1'b0;
        return;
      end
      r = mode == 0 ? 1'b1 : mode == 1 ? (phase % 4 == 0 || phase % 4 == 3) : 1'($urandom_range(0, 1));
      phase++;
      out_ready = r;
      if (k == ovr_at && !pulsed) begin
        pulsed = 1'b1;
        prod = ~p;
        prod_valid = 1'b1;
      end
      @(negedge clk);
      prod_valid = 1'b0;
      if (r) k++;
    end
    check("transfer finished in budget", WW'(k), WW'(NW));
    check_idle("after last");
  endtask
  initial begin
    int cyc;
    logic [PW-1:0] pa, pb;
    logic [PW-1:0] hi;
    hi = '0;
    hi[PW-1] = 1'b1;
    pa = rnd_prod();
    pb = rnd_prod();
    tbl[0] = '{PW'(1), 0, 64'h1, 64'h0};
    tbl[1] = '{'1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h003F_FFFF_FFFF_FFFF};
    tbl[2] = '{hi, 0, 64'h0, 64'h0020_0000_0000_0000};
    tbl[3] = '{'1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h003F_FFFF_FFFF_FFFF};
    tbl[4] = '{pa, 2, word_of(pa, 0), word_of(pa, NW - 1)};
    tbl[5] = '{pb, 1, word_of(pb, 0), word_of(pb, NW - 1)};
    repeat (3) @(negedge clk);
    check_idle("in reset");
    check("reset overrun", overrun0, 0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after reset");
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].p, tbl[i].mode, tbl[i].first0, tbl[i].first1, -1, -1, cyc);
      if (tbl[i].mode == 0) check("send cycles", WW'(cyc), WW'(NW));
    end
    for (int i = 0; i < 4; i++) begin
      pa = rnd_prod();
      run(pa, 2, word_of(pa, 0), word_of(pa, NW - 1), -1, -1, cyc);
    end
    check("no spurious overrun", overrun0, 0);
    pa = rnd_prod();
    run(pa, 0, word_of(pa, 0), word_of(pa, NW - 1), 5, -1, cyc);
    check("overrun0 set", overrun0, 1);
    check("overrun1 set", overrun1, 1);
    @(negedge clk);
    check("overrun sticky", overrun0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("overrun cleared", overrun0, 0);
    pa = rnd_prod();
    run(pa, 0, word_of(pa, 0), word_of(pa, NW - 1), -1, 9, cyc);
    pb = rnd_prod();
    run(pb, 1, word_of(pb, 0), word_of(pb, NW - 1), -1, -1, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
